mealyseq_sched: RTL and testbench

- Shares a single overlapping "1001" Mealy detector datapath among N serial bit streams.
- Each cycle, a round-robin arbiter grants one requesting channel. That channel's bit is evaluated against its saved detector state (per-channel context), and the updated state is written back.
- Sits between N serial receivers and the event/interrupt logic that consumes detection pulses.

---
 rtl/mealyseq_sched.sv | 120 ++++++++++++
 tb/tb_mealyseq_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mealyseq_sched.sv
// Overlapping "1001" Mealy detector time-shared by N serial streams through a round-robin arbiter.
// Optional saturating hit counter is built when MEALYSEQ_SCHED_HITCNT_EN is defined.
module mealyseq_sched #(
    parameter int N     = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     bit_in,
    input  logic [N-1:0]     clr,
    output logic [N-1:0]     gnt,
    output logic             hit,
    output logic [CH_W-1:0]  hit_ch,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle
        S1 = 2'd1,  // got "1"
        S2 = 2'd2,  // got "10"
        S3 = 2'd3   // got "100"
    } st_t;

    // Handshake: bit_in[k] is offered while req[k]=1 and is consumed at the
    // rising edge where gnt[k]=1; a channel under clr is never granted.
    st_t             ctx [N];
    logic [CH_W-1:0] ptr;
    logic [N-1:0]    eligible;
    logic            gvalid;
    logic [CH_W-1:0] gidx;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;
    st_t             cur_st;
    st_t             nxt_st;
    logic            cur_bit;
    logic            match;

    assign eligible = req & ~clr;

    // First eligible channel at or above the pointer, wrapping N-1 -> 0.
    always_comb begin
        gnt    = '0;
        gvalid = 1'b0;
        gidx   = '0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(N))
                sum = sum - (CH_W+1)'(N);
            cand = sum[CH_W-1:0];
            if (!gvalid && eligible[cand]) begin
                gvalid = 1'b1;
                gidx   = cand;
            end
        end
        if (rst_n && gvalid)
            gnt[gidx] = 1'b1;
    end

    assign cur_st  = ctx[gidx];
    assign cur_bit = bit_in[gidx];

    always_comb begin
        nxt_st = S0;
        match  = 1'b0;
        case (cur_st)
            S0: nxt_st = cur_bit ? S1 : S0;
            S1: nxt_st = cur_bit ? S1 : S2;
            S2: nxt_st = cur_bit ? S1 : S3;
            S3: begin
                nxt_st = cur_bit ? S1 : S0;
                match  = gvalid & cur_bit;
            end
            default: nxt_st = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++)
                ctx[k] <= S0;
            ptr    <= '0;
            hit    <= 1'b0;
            hit_ch <= '0;
        end else begin
            hit <= 1'b0;
            for (int k = 0; k < N; k++)
                if (clr[k])
                    ctx[k] <= S0;
            // A cleared channel is masked, so it can never also be gidx here.
            if (gvalid) begin
                ctx[gidx] <= nxt_st;
                ptr       <= (gidx == CH_W'(N-1)) ? '0 : gidx + 1'b1;
                if (match) begin
                    hit    <= 1'b1;
                    hit_ch <= gidx;
                end
            end
        end
    end

`ifdef MEALYSEQ_SCHED_HITCNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (match && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign hit_count = cnt_q;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_mealyseq_sched.sv
// Bench for mealyseq_sched: rotating-priority / last-four-bits reference model checked every cycle,
// plus directed scenarios with hand-computed hit channels, cycles and grant orders.
module tb_mealyseq_sched;

    localparam int N     = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     bit_in = '0;
    logic [N-1:0]     clr = '0;
    logic [N-1:0]     gnt;
    logic             hit;
    logic [CH_W-1:0]  hit_ch;
    logic [CNT_W-1:0] hit_count;

    always #5 clk = ~clk;

    mealyseq_sched #(.N(N), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bit_in    (bit_in),
        .clr       (clr),
        .gnt       (gnt),
        .hit       (hit),
        .hit_ch    (hit_ch),
        .hit_count (hit_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A hit is simply "the last four bits consumed on that channel since the
    // last clear/reset read 1,0,0,1".
    int          mptr = 0;
    logic [3:0]  hist [N];
    int          hlen [N];
    logic        exp_hit = 1'b0;
    int          exp_hit_ch = 0;
    longint      exp_cnt = 0;
    int          cyc = 0;

    logic [CH_W-1:0] exp_q[$];
    logic [CH_W-1:0] seen_q[$];
    int              seen_cyc[$];
    int              gseen_q[$];

    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mptr = 0;
        for (int k = 0; k < N; k++) begin
            hist[k] = '0;
            hlen[k] = 0;
        end
        exp_hit    = 1'b0;
        exp_hit_ch = 0;
        exp_cnt    = 0;
        cyc        = 0;
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin
        model_reset();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                if (clk == 1'b0) begin
                    check("rst_gnt", gnt, 0);
                    check("rst_hit", hit, 0);
                    check("rst_hit_ch", hit_ch, 0);
                    check("rst_hit_count", hit_count, 0);
                end
            end else begin
                int eg;
                eg = pick(req & ~clr, mptr);
                check("gnt", gnt, (eg < 0) ? 0 : (1 << eg));
                check("hit", hit, exp_hit);
                check("hit_ch", hit_ch, exp_hit_ch);
                check("hit_count", hit_count, exp_cnt);
                if (hit) begin
                    seen_q.push_back(hit_ch);
                    seen_cyc.push_back(cyc);
                end
                for (int k = 0; k < N; k++)
                    if (gnt[k]) gseen_q.push_back(k);
                // advance the model for the upcoming rising edge
                exp_hit = 1'b0;
                for (int k = 0; k < N; k++)
                    if (clr[k]) begin
                        hist[k] = '0;
                        hlen[k] = 0;
                    end
                if (eg >= 0) begin
                    hist[eg] = {hist[eg][2:0], bit_in[eg]};
                    hlen[eg]++;
                    if (hlen[eg] >= 4 && hist[eg] == 4'b1001) begin
                        exp_hit    = 1'b1;
                        exp_hit_ch = eg;
`ifdef MEALYSEQ_SCHED_HITCNT_EN
                        if (exp_cnt < (64'd1 << CNT_W) - 1) exp_cnt++;
`endif
                    end
                    mptr = (eg + 1) % N;
                end
                cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] c);
        req    = r;
        bit_in = b;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; bit_in = '0; clr = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete(); seen_q.delete(); seen_cyc.delete(); gseen_q.delete();
    endtask

    // ships hits seen so far against the expected queue
    task automatic check_hits(input string name);
        check({name, "_nhits"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check({name, "_ch"}, seen_q[i], exp_q[i]);
    endtask

    // async reset pulse between a rising edge and the following falling edge
    task automatic rst_pulse();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    int seq4 [4] = '{1, 0, 0, 1};
    int seq7 [7] = '{1, 0, 0, 1, 0, 0, 1};
    int lit_cnt;

    initial begin
        // ---- test 1: single channel 1001001 -> two hits, cycles 4 and 7
        do_reset();
        for (int i = 0; i < 7; i++) tick(4'b0001, N'(seq7[i]), '0);
        tick('0, '0, '0);
        tick('0, '0, '0);
        exp_q = '{0, 0};
        check_hits("t1");
        check("t1_cyc0", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, 4);
        check("t1_cyc1", (seen_cyc.size() > 1) ? seen_cyc[1] : -1, 7);
        check("t1_grants", gseen_q.size(), 7);

        // ---- test 2: all four channels fed 1001 in rotation
        do_reset();
        for (int c = 0; c < 16; c++) tick('1, {N{seq4[c/4][0]}}, '0);
        req = '0;
        repeat (2) tick('0, '0, '0);
        exp_q = '{0, 1, 2, 3};
        check_hits("t2");
        for (int i = 0; i < 4; i++)
            check("t2_cyc", (seen_cyc.size() > i) ? seen_cyc[i] : -1, 13 + i);
        for (int i = 0; i < 8; i++)
            check("t2_order", (gseen_q.size() > i) ? gseen_q[i] : -1, i % 4);

        // ---- test 3: stalled stream on channel 2 resumes
        do_reset();
        for (int i = 0; i < 3; i++) tick(4'b0100, {N{seq4[i][0]}}, '0);
        repeat (5) tick('0, '1, '0);
        tick(4'b0100, 4'b0100, '0);
        repeat (2) tick('0, '0, '0);
        exp_q = '{2};
        check_hits("t3");
        check("t3_cyc", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, 9);
        check("t3_grants", gseen_q.size(), 4);

        // ---- test 4: clear on channel 1 discards partial "10"
        do_reset();
        tick(4'b0010, 4'b0010, '0);
        tick(4'b0010, 4'b0000, '0);
        tick(4'b0010, 4'b0010, 4'b0010);
        tick(4'b0010, 4'b0000, '0);
        tick(4'b0010, 4'b0010, '0);
        check("t4_nohit", seen_q.size(), 0);
        for (int i = 0; i < 4; i++) tick(4'b0010, {N{seq4[i][0]}}, '0);
        repeat (2) tick('0, '0, '0);
        exp_q = '{1};
        check_hits("t4");
        check("t4_grants", gseen_q.size(), 8);

        // ---- test 5: wrap-around between channels 3 and 0
        do_reset();
        tick(4'b0100, '0, '0);
        for (int i = 0; i < 4; i++) tick(4'b1001, '0, '0);
        tick('0, '0, '0);
        for (int i = 0; i < 5; i++)
            check("t5_order", (gseen_q.size() > i) ? gseen_q[i] : -1, (i == 0) ? 2 : ((i % 2 == 1) ? 3 : 0));

        // ---- test 6: asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) tick(4'b0001, {N{seq4[i][0]}}, '0);
        check("t6_hit_pre", hit, 1);
        #1 rst_n = 1'b0;
        #1 check("t6_hit_in_rst", hit, 0);
        check("t6_cnt_in_rst", hit_count, 0);
        #1 rst_n = 1'b1;
        seen_q.delete();
        for (int i = 0; i < 3; i++) tick(4'b0001, {N{seq4[i][0]}}, '0);
        rst_pulse();
        tick(4'b0001, 4'b0001, '0);
        tick('0, '0, '0);
        check("t6_nohit", seen_q.size(), 0);
        check("t6_cnt0", hit_count, 0);
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 4; i++) tick(4'b0001, {N{seq4[i][0]}}, '0);
        tick('0, '0, '0);
        check("t6_nhits", seen_q.size(), 3);
`ifdef MEALYSEQ_SCHED_HITCNT_EN
        lit_cnt = 3;
`else
        lit_cnt = 0;
`endif
        check("t6_cnt3", hit_count, lit_cnt);

        // ---- random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r, b, cl;
            r  = N'($urandom);
            b  = N'($urandom);
            cl = '0;
            for (int k = 0; k < N; k++)
                cl[k] = ($urandom_range(0, 11) == 0);
            tick(r, b, cl);
            if ($urandom_range(0, 499) == 0) rst_pulse();
        end
        tick('0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
